gpu_ucode_sequencer: RTL and testbench

//  Fetches GPU micro-ops from gpu_ucode_rom (drives its iAddr, consumes its oUop) and executes them.

---
 rtl/gpu_ucode_sequencer.sv | 132 +++++++++++++
 tb/tb_gpu_ucode_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_ucode_sequencer.sv
// GPU micro-op sequencer: fetches uops from the ucode ROM, executes them on a 64x16
// register file and drives the VRAM read and framebuffer write handshakes.
module gpu_ucode_sequencer #(
  parameter int         OP_W     = 5,
  parameter int         PC_W     = 8,
  parameter logic [5:0] R_VADDR  = 6'd0,
  parameter logic [5:0] R_VDATA  = 6'd1,
  parameter logic [5:0] R_VSHL4  = 6'd2,
  parameter logic [5:0] R_BH     = 6'd3,
  parameter logic [5:0] R_BL     = 6'd4,
  parameter logic [5:0] R_FBADDR = 6'd5
) (
  input  logic            iClock,
  input  logic            iReset,
  input  logic            iEnable,
  output logic [PC_W-1:0] oUopAddr,
  input  logic [OP_W+17:0] iUop,
  output logic            oVmemReq,
  output logic [15:0]     oVmemAddr,
  input  logic            iVmemAck,
  input  logic [7:0]      iVmemData,
  output logic            oFbWrite,
  output logic [15:0]     oFbAddr,
  output logic [15:0]     oFbData,
  input  logic            iFbReady,
  output logic            oZero,
  output logic            oIllegal
);

  typedef enum logic [1:0] {IDLE, RUN, WAIT_VMEM, WAIT_FB} state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt, jtgt;
  logic [15:0]     rf [64];
  logic            zero, illegal_q, illegal;
  logic            wr_en, z_en;
  logic [5:0]      wr_idx, dst, srca, srcb;
  logic [15:0]     wr_val, lit;
  logic [OP_W-1:0] op;

  // R_VSHL4 is not storage: it presents vmem_data shifted up one nibble.
  function automatic logic [15:0] rd(input logic [5:0] idx);
    if (idx == R_VSHL4) return {4'h0, rf[R_VDATA][7:0], 4'h0};
    return rf[idx];
  endfunction

  assign op   = iUop[OP_W+17:18];
  assign dst  = iUop[17:12];
  assign srca = iUop[11:6];
  assign srcb = iUop[5:0];
  assign lit  = {4'h0, iUop[11:0]};
  assign jtgt = iUop[PC_W-1:0];

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    wr_en     = 1'b0;
    wr_idx    = dst;
    wr_val    = '0;
    z_en      = 1'b0;
    illegal   = 1'b0;
    case (state)
      IDLE: if (iEnable) state_nxt = RUN;
      RUN: begin
        pc_nxt    = pc + PC_W'(1);
        state_nxt = iEnable ? RUN : IDLE;
        case (op)
          OP_W'(0):  ;
          OP_W'(1):  begin wr_en = 1'b1; wr_val = lit; end
          OP_W'(2):  begin wr_en = 1'b1; wr_val = rd(srca); end
          OP_W'(3):  begin wr_en = 1'b1; z_en = 1'b1; wr_val = rd(srca) + rd(srcb); end
          OP_W'(4):  begin wr_en = 1'b1; z_en = 1'b1; wr_val = rd(dst) + lit; end
          OP_W'(5):  begin wr_en = 1'b1; z_en = 1'b1; wr_val = rd(srca) - rd(srcb); end
          OP_W'(6):  begin wr_en = 1'b1; z_en = 1'b1; wr_val = rd(dst) - lit; end
          OP_W'(7):  begin wr_en = 1'b1; z_en = 1'b1; wr_val = rd(srca) & rd(srcb); end
          OP_W'(8):  if (zero)  pc_nxt = jtgt;
          OP_W'(9):  if (!zero) pc_nxt = jtgt;
          OP_W'(10): pc_nxt = jtgt;
          // Memory ops park on their own PC until the handshake completes.
          OP_W'(11): begin pc_nxt = pc; state_nxt = WAIT_VMEM; end
          OP_W'(12): begin pc_nxt = pc; state_nxt = WAIT_FB; end
          OP_W'(13): begin
            wr_en  = 1'b1;
            z_en   = 1'b1;
            wr_idx = R_FBADDR;
            wr_val = rf[R_FBADDR] + 16'd1;
          end
          default:   illegal = 1'b1;
        endcase
      end
      WAIT_VMEM: if (iVmemAck) begin
        wr_en     = 1'b1;
        wr_idx    = R_VDATA;
        wr_val    = {8'h00, iVmemData};
        pc_nxt    = pc + PC_W'(1);
        state_nxt = iEnable ? RUN : IDLE;
      end
      WAIT_FB: if (iFbReady) begin
        pc_nxt    = pc + PC_W'(1);
        state_nxt = iEnable ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state     <= IDLE;
      pc        <= '0;
      zero      <= 1'b0;
      illegal_q <= 1'b0;
      for (int i = 0; i < 64; i++) rf[i] <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      illegal_q <= illegal;
      if (z_en) zero <= (wr_val == 16'd0);
      if (wr_en && wr_idx != R_VSHL4) rf[wr_idx] <= wr_val;
    end
  end

  // Requests decode straight from state so an async reset drops them at once.
  assign oUopAddr  = pc;
  assign oVmemReq  = (state == WAIT_VMEM);
  assign oVmemAddr = rf[R_VADDR];
  assign oFbWrite  = (state == WAIT_FB);
  assign oFbAddr   = rf[R_FBADDR];
  assign oFbData   = {rf[R_BH][7:0], rf[R_BL][7:0]};
  assign oZero     = zero;
  assign oIllegal  = illegal_q;

endmodule

// File: tb/tb_gpu_ucode_sequencer.sv
// Bench for gpu_ucode_sequencer: ALU/jump vector table run from a modelled ROM,
// then hand sequences for the VRAM and framebuffer handshakes, reset and illegal ops.
module tb_gpu_ucode_sequencer;

  logic        iClock, iReset, iEnable;
  logic [7:0]  oUopAddr;
  logic [22:0] iUop;
  logic        oVmemReq, iVmemAck, oFbWrite, iFbReady, oZero, oIllegal;
  logic [15:0] oVmemAddr, oFbAddr, oFbData;
  logic [7:0]  iVmemData;

  logic [22:0] rom [256];
  int          errors, checks;

  gpu_ucode_sequencer dut (
    .iClock(iClock), .iReset(iReset), .iEnable(iEnable),
    .oUopAddr(oUopAddr), .iUop(iUop),
    .oVmemReq(oVmemReq), .oVmemAddr(oVmemAddr), .iVmemAck(iVmemAck), .iVmemData(iVmemData),
    .oFbWrite(oFbWrite), .oFbAddr(oFbAddr), .oFbData(oFbData), .iFbReady(iFbReady),
    .oZero(oZero), .oIllegal(oIllegal)
  );

  assign iUop = rom[oUopAddr];

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  typedef struct {
    int          addr;
    logic [22:0] uop;
    int          pc;
    int          ridx;
    logic [15:0] rval;
    logic        z;
  } vec_t;

  vec_t tbl [25];

  function automatic logic [22:0] enc(input int op, input int d, input int a, input int b);
    return {op[4:0], d[5:0], a[5:0], b[5:0]};
  endfunction

  function automatic logic [22:0] encl(input int op, input int d, input int l);
    return {op[4:0], d[5:0], l[11:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge iClock);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 23'h0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    iReset = 1'b1; iEnable = 1'b0; iVmemAck = 1'b0; iVmemData = 8'h00; iFbReady = 1'b0;
    clear_rom();

    tbl[0]  = '{0,   encl(1, 7, 32),     1,   7,  16'h0020, 1'b0};
    tbl[1]  = '{1,   encl(6, 7, 32),     2,   7,  16'h0000, 1'b1};
    tbl[2]  = '{2,   encl(8, 0, 5),      5,   7,  16'h0000, 1'b1};
    tbl[3]  = '{5,   encl(1, 9, 'hFFF),  6,   9,  16'h0FFF, 1'b1};
    tbl[4]  = '{6,   encl(6, 11, 1),     7,   11, 16'hFFFF, 1'b0};
    tbl[5]  = '{7,   encl(4, 11, 1),     8,   11, 16'h0000, 1'b1};
    tbl[6]  = '{8,   encl(1, 12, 'h123), 9,   12, 16'h0123, 1'b1};
    tbl[7]  = '{9,   encl(1, 13, 'h0F0), 10,  13, 16'h00F0, 1'b1};
    tbl[8]  = '{10,  enc(3, 14, 12, 13), 11,  14, 16'h0213, 1'b0};
    tbl[9]  = '{11,  enc(5, 15, 13, 12), 12,  15, 16'hFFCD, 1'b0};
    tbl[10] = '{12,  enc(7, 16, 12, 13), 13,  16, 16'h0020, 1'b0};
    tbl[11] = '{13,  enc(7, 17, 12, 11), 14,  17, 16'h0000, 1'b1};
    tbl[12] = '{14,  encl(9, 0, 30),     15,  17, 16'h0000, 1'b1};
    tbl[13] = '{15,  enc(2, 18, 14, 0),  16,  18, 16'h0213, 1'b1};
    tbl[14] = '{16,  encl(10, 0, 40),    40,  18, 16'h0213, 1'b1};
    tbl[15] = '{40,  enc(5, 19, 14, 12), 41,  19, 16'h00F0, 1'b0};
    tbl[16] = '{41,  encl(8, 0, 60),     42,  19, 16'h00F0, 1'b0};
    tbl[17] = '{42,  encl(9, 0, 50),     50,  19, 16'h00F0, 1'b0};
    tbl[18] = '{50,  23'h0,              51,  19, 16'h00F0, 1'b0};
    tbl[19] = '{51,  encl(1, 2, 'h0AB),  52,  2,  16'h0000, 1'b0};
    tbl[20] = '{52,  encl(1, 1, 'h13C),  53,  1,  16'h013C, 1'b0};
    tbl[21] = '{53,  enc(2, 8, 2, 0),    54,  8,  16'h03C0, 1'b0};
    tbl[22] = '{54,  enc(2, 2, 8, 0),    55,  2,  16'h0000, 1'b0};
    tbl[23] = '{55,  encl(10, 0, 255),   255, 8,  16'h03C0, 1'b0};
    tbl[24] = '{255, 23'h0,              0,   8,  16'h03C0, 1'b0};
    foreach (tbl[i]) rom[tbl[i].addr] = tbl[i].uop;

    // Reset state and IDLE hold with iEnable low
    step(); step();
    iReset = 1'b0;
    step(); step();
    chk("reset_pc", oUopAddr, 0);
    chk("reset_zero", oZero, 0);
    chk("reset_vreq", oVmemReq, 0);
    chk("reset_fbw", oFbWrite, 0);
    chk("reset_ill", oIllegal, 0);

    // Vector table: one uop per edge; iEnable drops before the last one
    iEnable = 1'b1;
    step();
    chk("run_pc0", oUopAddr, 0);
    foreach (tbl[i]) begin
      if (i == 24) iEnable = 1'b0;
      step();
      chk($sformatf("vec%0d_pc", i), oUopAddr, tbl[i].pc);
      chk($sformatf("vec%0d_r%0d", i, tbl[i].ridx), dut.rf[tbl[i].ridx], tbl[i].rval);
      chk($sformatf("vec%0d_z", i), oZero, tbl[i].z);
    end
    step(); step();
    chk("idle_pc_held", oUopAddr, 0);
    chk("idle_r7_unchanged", dut.rf[7], 16'h0000);

    // VRAM read: build 0x9800 by doubling 0x980 four times
    iReset = 1'b1;
    clear_rom();
    rom[0] = encl(1, 0, 'h980);
    for (int i = 1; i <= 4; i++) rom[i] = enc(3, 0, 0, 0);
    rom[5] = encl(11, 0, 0);
    rom[6] = encl(11, 0, 0);
    rom[7] = encl(11, 0, 0);
    step();
    iReset = 1'b0;
    iEnable = 1'b1;
    step();
    repeat (5) step();
    chk("vaddr_built", oVmemAddr, 16'h9800);
    step();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("vreq_held%0d", k), oVmemReq, 1);
      chk($sformatf("vaddr_held%0d", k), oVmemAddr, 16'h9800);
      chk($sformatf("vpc_held%0d", k), oUopAddr, 5);
      chk($sformatf("vnofb%0d", k), oFbWrite, 0);
      if (k < 2) step();
    end
    iVmemAck = 1'b1; iVmemData = 8'hA5;
    step();
    iVmemAck = 1'b0; iVmemData = 8'h00;
    chk("vack_req_drop", oVmemReq, 0);
    chk("vack_data", dut.rf[1], 16'h00A5);
    chk("vack_pc", oUopAddr, 6);
    chk("vack_zero", oZero, 0);

    // Ack in the very cycle the request rises
    step();
    chk("vsame_req", oVmemReq, 1);
    iVmemAck = 1'b1; iVmemData = 8'h5A;
    step();
    iVmemAck = 1'b0;
    chk("vsame_drop", oVmemReq, 0);
    chk("vsame_data", dut.rf[1], 16'h005A);
    chk("vsame_pc", oUopAddr, 7);

    // Async reset while waiting on VRAM
    step();
    chk("vrst_req_pre", oVmemReq, 1);
    #2;
    iReset = 1'b1;
    iEnable = 1'b0;
    #1;
    chk("vrst_req_now", oVmemReq, 0);
    chk("vrst_pc_now", oUopAddr, 0);
    step();
    iReset = 1'b0;
    step(); step();
    chk("vrst_idle_pc", oUopAddr, 0);
    chk("vrst_idle_req", oVmemReq, 0);
    chk("vrst_regs", dut.rf[1], 16'h0000);

    // Framebuffer write then ginfbaddr, ready in the second wait cycle
    clear_rom();
    rom[0] = encl(1, 3, 'h012);
    rom[1] = encl(1, 4, 'h034);
    rom[2] = encl(1, 5, 'hFFF);
    rom[3] = enc(3, 5, 5, 5);
    rom[4] = encl(4, 5, 1);
    rom[5] = encl(12, 0, 0);
    rom[6] = encl(13, 0, 0);
    rom[7] = encl(31, 3, 'hFFF);
    iEnable = 1'b1;
    step();
    repeat (5) step();
    step();
    chk("fb_write", oFbWrite, 1);
    chk("fb_data", oFbData, 16'h1234);
    chk("fb_addr", oFbAddr, 16'h1FFF);
    chk("fb_novreq", oVmemReq, 0);
    step();
    chk("fb_held", oFbWrite, 1);
    chk("fb_held_pc", oUopAddr, 5);
    iFbReady = 1'b1;
    step();
    iFbReady = 1'b0;
    chk("fb_drop", oFbWrite, 0);
    chk("fb_pc", oUopAddr, 6);
    chk("fb_addr_nobump", oFbAddr, 16'h1FFF);
    step();
    chk("inc_fbaddr", oFbAddr, 16'h2000);
    chk("inc_zero", oZero, 0);
    chk("inc_pc", oUopAddr, 7);

    // Unsupported opcode: one-cycle flag, no register write
    step();
    chk("ill_pulse", oIllegal, 1);
    chk("ill_r3", dut.rf[3], 16'h0012);
    chk("ill_pc", oUopAddr, 8);
    step();
    chk("ill_clear", oIllegal, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
